// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, control-bundle bit positions and ALUOp codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int CTRL_W        = 9;
  localparam int BIT_REGDST    = 8;
  localparam int BIT_ALUSRC    = 7;
  localparam int BIT_MEMTOREG  = 6;
  localparam int BIT_REGWRITE  = 5;
  localparam int BIT_MEMREAD   = 4;
  localparam int BIT_MEMWRITE  = 3;
  localparam int BIT_BRANCH    = 2;
  localparam int BIT_ALUOP_MSB = 1;
  localparam int BIT_ALUOP_LSB = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/control.sv
// Main decoder of the single-cycle MIPS datapath: opcode -> registered control bundle.
module control
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [5:0]        opcode_i,
  output logic [CTRL_W-1:0] control_o,
  output logic              illegal_o
);

  logic [CTRL_W-1:0] ctrl_d;
  logic              illegal_d;

  // Unsupported opcodes fall through to an all-zero bundle so they cause no side effects.
  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_d[BIT_REGDST]                   = 1'b1;
        ctrl_d[BIT_REGWRITE]                 = 1'b1;
        ctrl_d[BIT_ALUOP_MSB:BIT_ALUOP_LSB]  = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_d[BIT_ALUSRC]                   = 1'b1;
        ctrl_d[BIT_MEMTOREG]                 = 1'b1;
        ctrl_d[BIT_REGWRITE]                 = 1'b1;
        ctrl_d[BIT_MEMREAD]                  = 1'b1;
        ctrl_d[BIT_ALUOP_MSB:BIT_ALUOP_LSB]  = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_d[BIT_ALUSRC]                   = 1'b1;
        ctrl_d[BIT_MEMWRITE]                 = 1'b1;
        ctrl_d[BIT_ALUOP_MSB:BIT_ALUOP_LSB]  = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_d[BIT_BRANCH]                   = 1'b1;
        ctrl_d[BIT_ALUOP_MSB:BIT_ALUOP_LSB]  = ALUOP_SUB;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      control_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      control_o <= ctrl_d;
      illegal_o <= illegal_d;
    end
  end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed cases, full opcode sweep and random traffic vs a table model.
module tb_control;

  logic       clk_i;
  logic       rst_n_i;
  logic [5:0] opcode_i;
  logic [8:0] control_o;
  logic       illegal_o;

  int checks;
  int errors;
  logic [9:0] expVal;

  control dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .opcode_i  (opcode_i),
    .control_o (control_o),
    .illegal_o (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: {illegal, control} straight from the instruction-class table.
  function automatic logic [9:0] refModel(input logic [5:0] op);
    if (op == 6'b000000)      return {1'b0, 9'b100100010};
    else if (op == 6'b100011) return {1'b0, 9'b011110000};
    else if (op == 6'b101011) return {1'b0, 9'b010001000};
    else if (op == 6'b000100) return {1'b0, 9'b000000101};
    else                      return {1'b1, 9'b000000000};
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive inputs just after an edge, then settle 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [5:0] op);
    rst_n_i  = rst;
    opcode_i = op;
    expVal   = rst ? refModel(op) : 10'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] legalOps [4];
    logic [5:0] illegalOps [3];
    int legalCount;
    checks = 0;
    errors = 0;
    rst_n_i  = 1'b0;
    opcode_i = 6'b000000;
    @(negedge clk_i);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 6'b000000);
      checkOutput("reset", {illegal_o, control_o}, 10'b0);
    end

    legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100};
    foreach (legalOps[i]) begin
      applyStimulus(1'b1, legalOps[i]);
      checkOutput($sformatf("legal_%b", legalOps[i]), {illegal_o, control_o}, expVal);
    end

    illegalOps = '{6'b111111, 6'b000010, 6'b001000};
    foreach (illegalOps[i]) begin
      applyStimulus(1'b1, illegalOps[i]);
      checkOutput($sformatf("illegal_%b", illegalOps[i]), {illegal_o, control_o}, {1'b1, 9'b0});
    end

    applyStimulus(1'b1, 6'b100011);
    opcode_i = 6'b000100;
    #3;
    checkOutput("latency_hold", {illegal_o, control_o}, refModel(6'b100011));
    @(posedge clk_i);
    #1;
    checkOutput("latency_update", {illegal_o, control_o}, refModel(6'b000100));

    applyStimulus(1'b1, 6'b100011);
    checkOutput("midreset_lw", {illegal_o, control_o}, 10'b0_011110000);
    applyStimulus(1'b0, 6'b100011);
    checkOutput("midreset_clear", {illegal_o, control_o}, 10'b0);
    applyStimulus(1'b1, 6'b000100);
    checkOutput("midreset_beq", {illegal_o, control_o}, 10'b0_000000101);

    legalCount = 0;
    for (int op = 0; op < 64; op++) begin
      applyStimulus(1'b1, 6'(op));
      checkOutput($sformatf("sweep_%b", 6'(op)), {illegal_o, control_o}, expVal);
      checkOutput($sformatf("memrw_%b", 6'(op)), {9'b0, control_o[4] & control_o[3]}, 10'b0);
      if (!illegal_o) legalCount++;
    end
    checkOutput("sweep_legal_count", 10'(legalCount), 10'd4);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 9) != 0), 6'($urandom_range(0, 63)));
      checkOutput("random", {illegal_o, control_o}, expVal);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control.md
Name: control

Overview:
- Main decoder of the MIPS single-cycle datapath.
- Maps the 6-bit instruction opcode (instr[31:26]) to a 9-bit bundle of datapath control signals.
- Output is registered: one clock of latency, cleared by synchronous reset.
- Sits between instruction fetch/decode and the register file, ALU control, data memory and PC-select logic.

Parameters:
- none

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset, synchronous, active-low
- opcode_i  input  6  instruction opcode field
- control_o  output  9  registered control bundle (bit map below)
- illegal_o  output  1  registered; 1 = opcode not supported

Behaviour:
- Bit map of control_o:
  - [8] RegDst
  - [7] ALUSrc
  - [6] MemtoReg
  - [5] RegWrite
  - [4] MemRead
  - [3] MemWrite
  - [2] Branch
  - [1:0] ALUOp (00 add, 01 subtract/compare, 10 funct-decoded)
- Decode table (opcode -> control_o, illegal_o):
  - 6'b000000 R-type -> 9'b100100010, 0
  - 6'b100011 lw -> 9'b011110000, 0
  - 6'b101011 sw -> 9'b010001000, 0
  - 6'b000100 beq -> 9'b000000101, 0
  - any other opcode (e.g. 6'b111111) -> 9'b000000000, 1
- Don't-care fields (RegDst/MemtoReg for sw and beq) are driven 0, never X.
- Default/illegal bundle has RegWrite, MemWrite, MemRead and Branch all 0, so an unsupported instruction has no architectural side effect.
- Timing:
  - Decode is purely combinational from opcode_i.
  - Result is captured on the rising edge of clk_i.
  - control_o and illegal_o reflect the opcode sampled at the previous edge (latency 1).
- Reset:
  - If rst_n_i == 0 at a rising edge: control_o <= 0 and illegal_o <= 0, regardless of opcode_i.
  - Reset has priority over decode.
  - Reset asserted mid-stream clears outputs at the next edge.
  - First edge after deassertion loads the decode of the current opcode_i.
- No handshake; a new opcode is accepted every cycle.
- Back-to-back changing opcodes produce back-to-back decoded outputs with no bubbles.
- X/Z on opcode_i is not defined behaviour and need not be handled.

Decomposition:
- Shared package (mips_pkg):
  - opcode localparams OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04
  - bit-index constants for the 9 control fields
  - ALUOp encodings ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10
- No sub-module needed: a combinational case-decode block (or function) feeding one output register stage inside control.

Test Plan:
- Reset: hold rst_n_i=0 for 2 edges with opcode_i=6'b000000 -> control_o=0, illegal_o=0 both cycles.
- Legal sequence: release reset, apply 000000, 100011, 101011, 000100 one per cycle -> control_o one cycle later = 100100010, 011110000, 010001000, 000000101; illegal_o=0 throughout.
- Illegal opcode: opcode_i=6'b111111 -> next edge control_o=000000000, illegal_o=1. Repeat for 6'b000010 and 6'b001000 -> same.
- Latency check: change opcode_i between edges -> outputs change only at the following rising edge, never combinationally.
- Mid-operation reset: apply lw, assert rst_n_i=0 for one edge -> control_o=0. Deassert with opcode_i=beq -> next edge control_o=000000101.
- Exhaustive sweep: all 64 opcodes -> only the four legal values give illegal_o=0. For every opcode, MemRead and MemWrite are never both 1.
